// File: rtl/mbist_pkg.sv
// mbist_pkg: definitions shared by the MBIST sequencer and its sub-module.
//   - ADDR_W_DEFAULT / DATA_W_DEFAULT : default memory geometry (16 x 8)
//   - state_e                         : March element states of the sequencer
package mbist_pkg;

    localparam int ADDR_W_DEFAULT = 4;
    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M0   = 3'd1,
        M1   = 3'd2,
        M2   = 3'd3,
        M3   = 3'd4,
        DONE = 3'd5
    } state_e;

endpackage

// File: rtl/mbist_addr_counter.sv
// mbist_addr_counter: loadable up/down address counter with terminal-count flag.
//   clk_i      : rising-edge clock
//   rst_ni     : asynchronous active-low reset (count -> 0)
//   load_i     : load load_val_i (has priority over en_i)
//   load_val_i : value to load
//   en_i       : step the count by one in the direction given by up_i
//   up_i       : 1 = count up, 0 = count down
//   cnt_o      : current count
//   tc_o       : terminal count for the current direction (all-ones up, zero down)
module mbist_addr_counter #(
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              en_i,
    input  logic              up_i,
    output logic [ADDR_W-1:0] cnt_o,
    output logic              tc_o
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = up_i ? (cnt_q + ONE) : (cnt_q - ONE);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = up_i ? (cnt_q == '1) : (cnt_q == '0);

endmodule

// File: rtl/mbist_sequencer.sv
// mbist_sequencer: March test sequencer (M0 up w0, M1 up r0/w1, M2 down r1/w0,
// M3 down r0) for a 2**ADDR_W x DATA_W memory, one operation per cycle.
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   NbarT     : 1 = test mode (start in IDLE, run in M0..M3, 0 freezes)
//   ld        : load/initialise, returns to IDLE; overrides NbarT
//   rdata     : memory read data, valid the cycle after re
//   addr      : memory address
//   wdata     : memory write data
//   we / re   : memory write / read strobes (never both high)
//   cout      : high while the test is complete (DONE)
//   fail      : sticky miscompare flag
//   fail_addr : address of the first miscompare
module mbist_sequencer
    import mbist_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              NbarT,
    input  logic              ld,
    input  logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              we,
    output logic              re,
    output logic              cout,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [DATA_W-1:0] ONES      = '1;

    state_e            state_q, state_d;
    logic              phase_q, phase_d;   // 0 = read op, 1 = write op (M1/M2)
    logic              act_q, act_d;       // strobes enabled this cycle
    logic              start;

    logic              cnt_load, cnt_en, cnt_up, cnt_tc;
    logic [ADDR_W-1:0] cnt_load_val, cnt_val;

    logic              cmp_vld_q;
    logic [DATA_W-1:0] exp_q;
    logic [ADDR_W-1:0] cmp_addr_q;
    logic              fail_q;
    logic [ADDR_W-1:0] fail_addr_q;

    logic              in_test, rd_op, last_op;

    mbist_addr_counter #(.ADDR_W(ADDR_W)) u_addr_cnt (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .en_i       (cnt_en),
        .up_i       (cnt_up),
        .cnt_o      (cnt_val),
        .tc_o       (cnt_tc)
    );

    assign in_test = (state_q == M0) || (state_q == M1) || (state_q == M2) || (state_q == M3);
    assign rd_op   = (state_q == M3) || (((state_q == M1) || (state_q == M2)) && !phase_q);
    // Every element ends its per-address work with a write, except M3 (read only).
    assign last_op = (state_q == M3) || !rd_op;
    assign cnt_up  = (state_q == M0) || (state_q == M1);

    // Outputs depend only on registered state, phase, activity and counter.
    assign re        = act_q && in_test && rd_op;
    assign we        = act_q && in_test && !rd_op;
    assign wdata     = (state_q == M1) ? ONES : '0;
    assign addr      = in_test ? cnt_val : '0;
    assign cout      = (state_q == DONE);
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        act_d        = act_q;
        start        = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        if (ld) begin
            state_d  = IDLE;
            phase_d  = 1'b0;
            act_d    = 1'b0;
            cnt_load = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (NbarT) begin
                        state_d  = M0;
                        phase_d  = 1'b0;
                        act_d    = 1'b1;
                        cnt_load = 1'b1;
                        start    = 1'b1;
                    end
                end
                M0, M1, M2, M3: begin
                    // The op shown this cycle completes at this edge if it was
                    // active; NbarT only decides whether the next op is issued.
                    act_d = NbarT;
                    if (act_q) begin
                        if (!last_op) begin
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (!cnt_tc) begin
                                cnt_en = 1'b1;
                            end else begin
                                // Terminal address: move to the next element and
                                // preset its start address instead of wrapping.
                                cnt_load = 1'b1;
                                case (state_q)
                                    M0: state_d = M1;
                                    M1: begin
                                        state_d      = M2;
                                        cnt_load_val = ADDR_LAST;
                                    end
                                    M2: begin
                                        state_d      = M3;
                                        cnt_load_val = ADDR_LAST;
                                    end
                                    default: begin
                                        state_d = DONE;
                                        act_d   = 1'b0;
                                    end
                                endcase
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            act_q       <= 1'b0;
            cmp_vld_q   <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            act_q     <= act_d;
            cmp_vld_q <= re;
            if (start) begin
                fail_q      <= 1'b0;
                fail_addr_q <= '0;
            end else if (cmp_vld_q && (rdata != exp_q)) begin
                fail_q <= 1'b1;
                if (!fail_q) begin
                    fail_addr_q <= cmp_addr_q;
                end
            end
        end
    end

    // Expected data and address of the read in flight; only meaningful when
    // cmp_vld_q is set, so no reset is needed.
    always_ff @(posedge clk) begin
        exp_q      <= (state_q == M2) ? ONES : '0;
        cmp_addr_q <= cnt_val;
    end

endmodule

// File: tb/tb_mbist_sequencer.sv
module tb_mbist_sequencer;

    localparam int N    = 16;
    localparam int NOPS = 96;

    logic       clk = 1'b0;
    logic       rst, NbarT, ld;
    logic [7:0] rdata;
    logic [3:0] addr, fail_addr;
    logic [7:0] wdata;
    logic       we, re, cout, fail;

    always #5 clk = ~clk;

    mbist_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .NbarT(NbarT), .ld(ld), .rdata(rdata),
        .addr(addr), .wdata(wdata), .we(we), .re(re), .cout(cout),
        .fail(fail), .fail_addr(fail_addr)
    );

    // Memory with fault masks: sa0/sa1 stuck bits, tf = bits that cannot fall 1->0.
    logic [7:0] mem [N];
    logic [7:0] sa0 [N];
    logic [7:0] sa1 [N];
    logic [7:0] tf  [N];
    logic       mem_clr;

    function automatic logic [7:0] cell_write(int a, logic [7:0] old, logic [7:0] d);
        return ((d | (old & tf[a])) & ~sa0[a]) | sa1[a];
    endfunction

    function automatic logic [7:0] cell_read(int a, logic [7:0] v);
        return (v & ~sa0[a]) | sa1[a];
    endfunction

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < N; i++) mem[i] <= 8'h00;
        end else if (we) begin
            mem[addr] <= cell_write(int'(addr), mem[addr], wdata);
        end
        if (re) rdata <= cell_read(int'(addr), mem[addr]);
    end

    typedef struct packed {
        logic       w;
        logic       r;
        logic [3:0] a;
        logic [7:0] d;
    } op_t;

    op_t        exp_q[$];
    logic [7:0] exp_x[$];
    op_t        obs_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc, both_cnt, pause_viol;
    bit done_flag;

    task automatic push_op(bit w, int a, logic [7:0] d, logic [7:0] x);
        op_t o;
        o.w = w; o.r = !w; o.a = 4'(a); o.d = w ? d : 8'h00;
        exp_q.push_back(o);
        exp_x.push_back(x);
    endtask

    // The March algorithm as a flat list of operations.
    task automatic build_march();
        exp_q.delete(); exp_x.delete();
        for (int a = 0; a < N; a++) push_op(1, a, 8'h00, 8'h00);
        for (int a = 0; a < N; a++) begin
            push_op(0, a, 8'h00, 8'h00);
            push_op(1, a, 8'hFF, 8'h00);
        end
        for (int a = N - 1; a >= 0; a--) begin
            push_op(0, a, 8'h00, 8'hFF);
            push_op(1, a, 8'h00, 8'h00);
        end
        for (int a = N - 1; a >= 0; a--) push_op(0, a, 8'h00, 8'h00);
    endtask

    // Replay the first nops operations on a faulty memory, report first miscompare.
    task automatic model_run(input int nops, output bit f, output logic [3:0] fa);
        logic [7:0] m [N];
        logic [7:0] got;
        for (int i = 0; i < N; i++) m[i] = 8'h00;
        f = 1'b0; fa = 4'd0;
        for (int k = 0; k < nops; k++) begin
            if (exp_q[k].w) begin
                m[exp_q[k].a] = cell_write(int'(exp_q[k].a), m[exp_q[k].a], exp_q[k].d);
            end else begin
                got = cell_read(int'(exp_q[k].a), m[exp_q[k].a]);
                if (got !== exp_x[k] && !f) begin
                    f = 1'b1; fa = exp_q[k].a;
                end
            end
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < N; i++) begin
            sa0[i] = 8'h00; sa1[i] = 8'h00; tf[i] = 8'h00;
        end
    endtask

    task automatic do_ld();
        @(negedge clk);
        ld = 1'b1; NbarT = 1'b0; mem_clr = 1'b1;
        @(negedge clk);
        ld = 1'b0; mem_clr = 1'b0;
    endtask

    // Raise NbarT and record every strobe until cout, stop_at ops, or budget.
    task automatic collect(input int pause_at, input int pause_len, input int stop_at, input int budget);
        int  pl;
        bit  paused, nb_prev;
        op_t o;
        obs_q.delete();
        cyc = 0; done_flag = 0; both_cnt = 0; pause_viol = 0; pl = 0; paused = 0;
        NbarT = 1'b1; nb_prev = 1'b1;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (cout) begin
                done_flag = 1;
                break;
            end
            if (we || re) begin
                o.w = we; o.r = re; o.a = addr; o.d = we ? wdata : 8'h00;
                obs_q.push_back(o);
                if (!nb_prev) pause_viol++;
            end
            if (we && re) both_cnt++;
            if (stop_at > 0 && obs_q.size() == stop_at) break;
            if (pause_at > 0 && !paused && obs_q.size() == pause_at) begin
                NbarT = 1'b0; paused = 1; pl = pause_len;
            end else if (pl > 0) begin
                pl--;
                if (pl == 0) NbarT = 1'b1;
            end
            nb_prev = NbarT;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; NbarT = 1'b0; ld = 1'b0; mem_clr = 1'b0;
        #1 rst = 1'b0;
        #5;
        n_checks++;
        if ({we, re, cout, fail} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got we/re/cout/fail=%b want 0000", {we, re, cout, fail});
        end
        n_checks++;
        if (addr !== 4'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", addr); end
        n_checks++;
        if (wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata got %h want 00", wdata); end
        n_checks++;
        if (fail_addr !== 4'd0) begin n_fail++; $display("FAIL reset_fail_addr got %0d want 0", fail_addr); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({we, re, cout} !== 3'b000) begin
            n_fail++; $display("FAIL idle_hold got we/re/cout=%b want 000", {we, re, cout});
        end
    endtask

    task automatic test_full_pass();
        bit         ef;
        logic [3:0] efa;
        clear_faults();
        model_run(NOPS, ef, efa);
        do_ld();
        collect(0, 0, 0, 300);
        n_checks++;
        if (!done_flag || cyc != NOPS + 1) begin
            n_fail++; $display("FAIL pass_cycles got cout at cycle %0d (done=%0b) want %0d", cyc, done_flag, NOPS + 1);
        end
        n_checks++;
        if (obs_q.size() != NOPS) begin n_fail++; $display("FAIL pass_opcount got %0d want %0d", obs_q.size(), NOPS); end
        for (int k = 0; k < obs_q.size() && k < NOPS; k++) begin
            n_checks++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL pass_op[%0d] got w%0b r%0b a%0d d%h want w%0b r%0b a%0d d%h", k,
                         obs_q[k].w, obs_q[k].r, obs_q[k].a, obs_q[k].d, exp_q[k].w, exp_q[k].r, exp_q[k].a, exp_q[k].d);
            end
        end
        n_checks++;
        if (both_cnt != 0) begin n_fail++; $display("FAIL pass_we_re_both got %0d cycles want 0", both_cnt); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (fail !== ef) begin n_fail++; $display("FAIL pass_fail got %0b want %0b", fail, ef); end
        n_checks++;
        if (cout !== 1'b1) begin n_fail++; $display("FAIL done_hold_cout got %0b want 1", cout); end
        n_checks++;
        if ({we, re, addr, wdata} !== 14'd0) begin
            n_fail++; $display("FAIL done_outputs got we%0b re%0b a%0d d%h want all 0", we, re, addr, wdata);
        end
    endtask

    task automatic test_fault_addr();
        bit         ef;
        logic [3:0] efa;
        clear_faults();
        sa0[5] = 8'h08;
        tf[9]  = 8'h08;
        model_run(NOPS, ef, efa);
        do_ld();
        collect(0, 0, 0, 300);
        @(negedge clk);
        n_checks++;
        if (!done_flag || cyc != NOPS + 1) begin
            n_fail++; $display("FAIL fault_cycles got %0d (done=%0b) want %0d", cyc, done_flag, NOPS + 1);
        end
        n_checks++;
        if (fail !== ef) begin n_fail++; $display("FAIL fault_flag got %0b want %0b", fail, ef); end
        n_checks++;
        if (fail_addr !== efa) begin n_fail++; $display("FAIL fault_first_addr got %0d want %0d", fail_addr, efa); end
        clear_faults();
    endtask

    task automatic test_pause();
        int pat, plen;
        clear_faults();
        for (int it = 0; it < 3; it++) begin
            if (it == 0) begin
                pat = int'($urandom_range(79, 49)); plen = 3;
            end else begin
                pat = int'($urandom_range(95, 1)); plen = int'($urandom_range(5, 1));
            end
            do_ld();
            collect(pat, plen, 0, 300);
            n_checks++;
            if (!done_flag || cyc != NOPS + 1 + plen) begin
                n_fail++; $display("FAIL pause_cycles at op %0d len %0d got %0d want %0d", pat, plen, cyc, NOPS + 1 + plen);
            end
            n_checks++;
            if (pause_viol != 0) begin n_fail++; $display("FAIL pause_strobes got %0d want 0", pause_viol); end
            n_checks++;
            if (obs_q.size() != NOPS) begin n_fail++; $display("FAIL pause_opcount got %0d want %0d", obs_q.size(), NOPS); end
            for (int k = 0; k < obs_q.size() && k < NOPS; k++) begin
                n_checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL pause_op[%0d] got w%0b r%0b a%0d d%h want w%0b r%0b a%0d d%h", k,
                             obs_q[k].w, obs_q[k].r, obs_q[k].a, obs_q[k].d, exp_q[k].w, exp_q[k].r, exp_q[k].a, exp_q[k].d);
                end
            end
            @(negedge clk);
            n_checks++;
            if (fail !== 1'b0) begin n_fail++; $display("FAIL pause_fail got %0b want 0", fail); end
        end
    endtask

    task automatic test_ld_abort();
        int         k;
        bit         ef;
        logic [3:0] efa;
        clear_faults();
        sa1[2] = 8'h10;
        k = int'($urandom_range(47, 24));
        model_run(k, ef, efa);
        do_ld();
        collect(0, 0, k, 300);
        ld = 1'b1; NbarT = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({we, re, cout, addr} !== 7'd0) begin
            n_fail++; $display("FAIL abort_idle got we%0b re%0b cout%0b a%0d want all 0", we, re, cout, addr);
        end
        n_checks++;
        if (fail !== ef || fail_addr !== efa) begin
            n_fail++; $display("FAIL abort_fail_held got %0b/%0d want %0b/%0d", fail, fail_addr, ef, efa);
        end
        ld = 1'b0;
        model_run(NOPS, ef, efa);
        collect(0, 0, 0, 300);
        @(negedge clk);
        n_checks++;
        if (obs_q.size() == 0 || obs_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL restart_first_op got %0d ops, want first op w1 a0 d00", obs_q.size());
        end
        n_checks++;
        if (!done_flag || cyc != NOPS + 1 || obs_q.size() != NOPS) begin
            n_fail++; $display("FAIL restart_run got cycles %0d ops %0d want %0d/%0d", cyc, obs_q.size(), NOPS + 1, NOPS);
        end
        n_checks++;
        if (fail !== ef || fail_addr !== efa) begin
            n_fail++; $display("FAIL restart_fail got %0b/%0d want %0b/%0d", fail, fail_addr, ef, efa);
        end
        clear_faults();
    endtask

    task automatic test_reset_mid();
        int k, strobes;
        clear_faults();
        sa0[5] = 8'h08;
        k = int'($urandom_range(95, 81));
        do_ld();
        collect(0, 0, k, 300);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({we, re, cout, fail} !== 4'b0000) begin
            n_fail++; $display("FAIL async_reset_flags got we/re/cout/fail=%b want 0000", {we, re, cout, fail});
        end
        n_checks++;
        if ({addr, fail_addr, wdata} !== 16'd0) begin
            n_fail++; $display("FAIL async_reset_data got a%0d fa%0d d%h want 0", addr, fail_addr, wdata);
        end
        @(negedge clk);
        NbarT = 1'b0;
        rst = 1'b1;
        strobes = 0;
        repeat (4) begin
            @(negedge clk);
            if (we || re || cout) strobes++;
        end
        n_checks++;
        if (strobes != 0) begin n_fail++; $display("FAIL post_reset_idle got %0d active cycles want 0", strobes); end
        clear_faults();
        collect(0, 0, 0, 300);
        n_checks++;
        if (!done_flag || cyc != NOPS + 1) begin
            n_fail++; $display("FAIL post_reset_run got %0d want %0d", cyc, NOPS + 1);
        end
    endtask

    task automatic test_closed_loop();
        int         cout_cnt, n;
        bit         ef;
        logic [3:0] efa;
        clear_faults();
        sa0[5] = 8'h08;
        model_run(NOPS, ef, efa);
        do_ld();
        ld = 1'b1; NbarT = 1'b0;
        repeat (int'($urandom_range(4, 1))) @(negedge clk);
        ld = 1'b0; NbarT = 1'b1;
        cout_cnt = 0; n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (cout) begin
                cout_cnt++;
                ld = 1'b1; NbarT = 1'b0;
                break;
            end
        end
        @(negedge clk);
        n_checks++;
        if (cout_cnt != 1 || cout !== 1'b0 || n != NOPS + 1) begin
            n_fail++; $display("FAIL loop_cout got pulses %0d cout %0b at %0d want 1/0/%0d", cout_cnt, cout, n, NOPS + 1);
        end
        n_checks++;
        if ({we, re, addr} !== 6'd0) begin
            n_fail++; $display("FAIL loop_idle got we%0b re%0b a%0d want 0", we, re, addr);
        end
        n_checks++;
        if (fail !== ef || fail_addr !== efa) begin
            n_fail++; $display("FAIL loop_fail_kept got %0b/%0d want %0b/%0d", fail, fail_addr, ef, efa);
        end
        ld = 1'b0;
        clear_faults();
    endtask

    initial begin
        clear_faults();
        build_march();
        test_reset();
        test_full_pass();
        test_fault_addr();
        test_pause();
        test_ld_abort();
        test_reset_mid();
        test_closed_loop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

endmodule
